multicycle_ctrl: RTL and testbench

Control FSM that sequences the multicycle MIPS datapath, the shared-memory successor to the single-cycle core. One memory port serves both instruction fetch and data access. The block sequences each instruction through fetch/decode/execute/memory/writeback states and drives all datapath enables and muxes. A `mem_ready` handshake lets slow memory stall fetch and data cycles.

---
 rtl/multicycle_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM sharing one memory port for fetch and data.
// Optional bne support is enabled by defining MULTICYCLE_CTRL_BNE_EN.
module multicycle_ctrl #(
    parameter logic FETCH_ADDR_SEL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t state_q, state_d;
    aluop_t aluop;
    logic   pcwrite, branch, branch_ne;
    logic   irwrite_raw, memwrite_raw, regwrite_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite      = 1'b0;
        branch       = 1'b0;
        branch_ne    = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        iord         = FETCH_ADDR_SEL;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb     = 2'b01;
                pcwrite     = mem_ready;
                irwrite_raw = mem_ready;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = ~FETCH_ADDR_SEL;
            S_MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            S_MEMWR: begin
                iord         = ~FETCH_ADDR_SEL;
                memwrite_raw = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regwrite_raw = 1'b1;
                regdst       = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_BNE_EN
            S_BNEEX: begin
                alusrca   = 1'b1;
                aluop     = ALUOP_SUB;
                pcsrc     = 2'b01;
                branch_ne = 1'b1;
            end
`endif
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  regwrite_raw = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            ALUOP_SUB: alucontrol = 3'b110;
            ALUOP_FUNCT: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default:   alucontrol = 3'b010;
        endcase
    end

    // Write enables are gated by reset itself so nothing pulses while it is held.
    assign pcen     = reset & (pcwrite | (branch & zero) | (branch_ne & ~zero));
    assign irwrite  = reset & irwrite_raw;
    assign memwrite = reset & memwrite_raw;
    assign regwrite = reset & regwrite_raw;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .iord       (iord),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
        #1;
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_irwrite", 8'(irwrite), 8'd0);
        chk("rst_pcen", 8'(pcen), 8'd0);
        chk("rst_alusrcb", 8'(alusrcb), 8'd1);
        chk("rst_iord", 8'(iord), 8'd0);
        tick(); tick();
        chk("rst_hold_state", 8'(state), 8'd0);
        chk("rst_hold_memwrite", 8'(memwrite), 8'd0);

        // lw: 0,1,2,3,4,0
        reset = 1'b1; #1;
        chk("lw_f_irwrite", 8'(irwrite), 8'd1);
        chk("lw_f_pcen", 8'(pcen), 8'd1);
        tick();
        chk("lw_d_state", 8'(state), 8'd1);
        chk("lw_d_irwrite", 8'(irwrite), 8'd0);
        chk("lw_d_alusrcb", 8'(alusrcb), 8'd3);
        tick();
        chk("lw_a_state", 8'(state), 8'd2);
        chk("lw_a_alusrcb", 8'(alusrcb), 8'd2);
        chk("lw_a_alusrca", 8'(alusrca), 8'd1);
        tick();
        chk("lw_r_state", 8'(state), 8'd3);
        chk("lw_r_iord", 8'(iord), 8'd1);
        chk("lw_r_regwrite", 8'(regwrite), 8'd0);
        tick();
        chk("lw_wb_state", 8'(state), 8'd4);
        chk("lw_wb_regwrite", 8'(regwrite), 8'd1);
        chk("lw_wb_memtoreg", 8'(memtoreg), 8'd1);
        chk("lw_wb_regdst", 8'(regdst), 8'd0);
        tick();
        chk("lw_end_state", 8'(state), 8'd0);

        // sw with two stall cycles in MEMWR
        op = 6'b101011;
        tick(); tick(); tick();
        chk("sw_state", 8'(state), 8'd5);
        chk("sw_iord", 8'(iord), 8'd1);
        mem_ready = 1'b0; #1;
        chk("sw_memwrite0", 8'(memwrite), 8'd1);
        tick();
        chk("sw_hold1_state", 8'(state), 8'd5);
        chk("sw_memwrite1", 8'(memwrite), 8'd1);
        tick();
        chk("sw_hold2_state", 8'(state), 8'd5);
        mem_ready = 1'b1; #1;
        chk("sw_memwrite2", 8'(memwrite), 8'd1);
        chk("sw_regwrite", 8'(regwrite), 8'd0);
        tick();
        chk("sw_end_state", 8'(state), 8'd0);
        chk("sw_end_memwrite", 8'(memwrite), 8'd0);

        // R-type slt then and
        op = 6'b000000; funct = 6'b101010;
        tick(); tick();
        chk("slt_state", 8'(state), 8'd6);
        chk("slt_alucontrol", 8'(alucontrol), 8'd7);
        chk("slt_alusrcb", 8'(alusrcb), 8'd0);
        tick();
        chk("rwb_state", 8'(state), 8'd7);
        chk("rwb_regdst", 8'(regdst), 8'd1);
        chk("rwb_regwrite", 8'(regwrite), 8'd1);
        tick();
        funct = 6'b100100;
        tick(); tick();
        chk("and_alucontrol", 8'(alucontrol), 8'd0);
        funct = 6'b100101; #1;
        chk("or_alucontrol", 8'(alucontrol), 8'd1);
        funct = 6'b111111; #1;
        chk("badfunct_alucontrol", 8'(alucontrol), 8'd2);
        tick(); tick();
        chk("and_end_state", 8'(state), 8'd0);

        // beq taken / not taken
        op = 6'b000100; zero = 1'b1;
        tick(); tick();
        chk("beq_state", 8'(state), 8'd8);
        chk("beq_pcen_z1", 8'(pcen), 8'd1);
        chk("beq_pcsrc", 8'(pcsrc), 8'd1);
        chk("beq_alucontrol", 8'(alucontrol), 8'd6);
        zero = 1'b0; #1;
        chk("beq_pcen_z0", 8'(pcen), 8'd0);
        tick();
        chk("beq_end_state", 8'(state), 8'd0);

        // addi
        op = 6'b001000;
        tick(); tick();
        chk("addi_ex_state", 8'(state), 8'd9);
        chk("addi_ex_alusrcb", 8'(alusrcb), 8'd2);
        tick();
        chk("addi_wb_state", 8'(state), 8'd10);
        chk("addi_wb_regwrite", 8'(regwrite), 8'd1);
        chk("addi_wb_regdst", 8'(regdst), 8'd0);
        chk("addi_wb_memtoreg", 8'(memtoreg), 8'd0);
        tick();

        // j
        op = 6'b000010;
        tick(); tick();
        chk("j_state", 8'(state), 8'd11);
        chk("j_pcen", 8'(pcen), 8'd1);
        chk("j_pcsrc", 8'(pcsrc), 8'd2);
        tick();
        chk("j_end_state", 8'(state), 8'd0);

        // unknown op, then a fetch stall
        op = 6'b111111;
        tick();
        chk("nop_d_state", 8'(state), 8'd1);
        tick();
        chk("nop_end_state", 8'(state), 8'd0);
        chk("nop_regwrite", 8'(regwrite), 8'd0);
        chk("nop_memwrite", 8'(memwrite), 8'd0);
        mem_ready = 1'b0; #1;
        chk("stall_irwrite", 8'(irwrite), 8'd0);
        chk("stall_pcen", 8'(pcen), 8'd0);
        tick();
        chk("stall_state", 8'(state), 8'd0);
        mem_ready = 1'b1; #1;

        // bne
        op = 6'b000101; zero = 1'b0;
        tick(); tick();
`ifdef MULTICYCLE_CTRL_BNE_EN
        chk("bne_state", 8'(state), 8'd12);
        chk("bne_pcen_z0", 8'(pcen), 8'd1);
        zero = 1'b1; #1;
        chk("bne_pcen_z1", 8'(pcen), 8'd0);
        tick();
`endif
        chk("bne_end_state", 8'(state), 8'd0);

        // async reset while in MEMWR
        op = 6'b101011; zero = 1'b0;
        tick(); tick(); tick();
        chk("ar_state_pre", 8'(state), 8'd5);
        mem_ready = 1'b0; #1;
        reset = 1'b0; #1;
        chk("ar_state", 8'(state), 8'd0);
        chk("ar_memwrite", 8'(memwrite), 8'd0);
        chk("ar_irwrite", 8'(irwrite), 8'd0);
        tick();
        chk("ar_hold_state", 8'(state), 8'd0);
        reset = 1'b1; #1;
        chk("ar_rel_state", 8'(state), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
